// File: rtl/m_game_ctrl_pkg.sv
// Shared game definitions: controller state encodings, default game limits
// and small state-class helpers used by the controller and its stages.
package m_game_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_TICK = 4'd1,
        S_LOGIC     = 4'd2,
        S_COLLIDE   = 4'd3,
        S_RENDER    = 4'd4,
        S_CHECK     = 4'd5,
        S_WON       = 4'd6,
        S_LOST      = 4'd7,
        S_FAULT     = 4'd8
    } game_state_t;

    localparam logic [7:0]  WON_SCORE_DEFAULT = 8'd188;
    localparam int unsigned TIMEOUT_DEFAULT   = 1023;
    localparam int unsigned WDOG_W            = 10;
    localparam logic [3:0]  OVERRUN_MAX       = 4'd15;

    // States in which a pipeline stage holds its run enable.
    function automatic logic is_stage(game_state_t s);
        return (s == S_LOGIC) || (s == S_COLLIDE) || (s == S_RENDER);
    endfunction

    // States in which a move tick is recorded (game in progress).
    function automatic logic tick_armed(game_state_t s);
        return (s == S_WAIT_TICK) || is_stage(s) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/m_game_ctrl_watchdog.sv
// Stage watchdog: counts cycles a stage holds its enable and flags the cycle
// in which the TIMEOUT-th enabled cycle elapses without the stage finishing.
module m_stage_watchdog
    import m_game_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [WDOG_W-1:0] LAST = WDOG_W'(TIMEOUT - 1);

    logic [WDOG_W-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    // count holds the enabled cycles already elapsed, so this cycle is the last allowed.
    assign expired = count_en && (count >= LAST);

endmodule

// File: rtl/m_game_ctrl.sv
// Game sequencer: on each move tick runs logic, collision and render stages
// in turn, then decides won / lost / continue; a watchdog traps hung stages.
module m_game_ctrl
    import m_game_ctrl_pkg::*;
#(
    parameter logic [7:0]  WON_SCORE = WON_SCORE_DEFAULT,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       hs_enable,
    input  logic       start_key,
    input  logic       logic_finished,
    input  logic       collision_finished,
    input  logic       ghost_collision,
    input  logic       render_finished,
    input  logic [7:0] score,
    output logic       logic_enable,
    output logic       collision_enable,
    output logic       render_enable,
    output logic       stage_ack,
    output logic       game_reset,
    output logic       game_won,
    output logic       game_over,
    output logic       fault,
    output logic [3:0] overrun_count,
    output logic [3:0] state_dbg
);

    game_state_t state, state_next;
    logic        tick_pending;
    logic        hit_r;
    logic        stage_done;
    logic        wd_expired;

    m_stage_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_next != state),
        .count_en (is_stage(state)),
        .expired  (wd_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stage_done = 1'b0;
        unique case (state)
            S_IDLE, S_WON, S_LOST: begin
                if (start_key) state_next = S_WAIT_TICK;
            end
            S_WAIT_TICK: begin
                if (tick_pending || hs_enable) state_next = S_LOGIC;
            end
            S_LOGIC: begin
                stage_done = logic_finished;
                if (logic_finished)  state_next = S_COLLIDE;
                else if (wd_expired) state_next = S_FAULT;
            end
            S_COLLIDE: begin
                stage_done = collision_finished;
                if (collision_finished) state_next = S_RENDER;
                else if (wd_expired)    state_next = S_FAULT;
            end
            S_RENDER: begin
                stage_done = render_finished;
                if (render_finished) state_next = S_CHECK;
                else if (wd_expired) state_next = S_FAULT;
            end
            S_CHECK: begin
                if (hit_r)                   state_next = S_LOST;
                else if (score >= WON_SCORE) state_next = S_WON;
                else                         state_next = S_WAIT_TICK;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_IDLE;
        endcase
    end

    // Pulses are gated by reset so nothing leaks out while it is held.
    assign stage_ack  = stage_done && !reset;
    assign game_reset = start_key && !reset &&
                        ((state == S_IDLE) || (state == S_WON) || (state == S_LOST));

    assign logic_enable     = (state == S_LOGIC);
    assign collision_enable = (state == S_COLLIDE);
    assign render_enable    = (state == S_RENDER);
    assign game_won         = (state == S_WON);
    assign game_over        = (state == S_LOST);
    assign fault            = (state == S_FAULT);
    assign state_dbg        = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_pending  <= 1'b0;
            overrun_count <= '0;
            hit_r         <= 1'b0;
        end else if (game_reset) begin
            tick_pending  <= 1'b0;
            overrun_count <= '0;
            hit_r         <= 1'b0;
        end else begin
            if (tick_armed(state) && hs_enable && tick_pending &&
                (overrun_count != OVERRUN_MAX)) begin
                overrun_count <= overrun_count + 1'b1;
            end
            // Entering LOGIC consumes the tick, even one arriving that same cycle.
            if ((state == S_WAIT_TICK) && (state_next == S_LOGIC)) begin
                tick_pending <= 1'b0;
            end else if (tick_armed(state) && hs_enable) begin
                tick_pending <= 1'b1;
            end
            if ((state == S_COLLIDE) && collision_finished) begin
                hit_r <= ghost_collision;
            end
        end
    end

endmodule

// File: tb/tb_m_game_ctrl.sv
// Randomised scoreboard bench for m_game_ctrl: a game-level reference model
// queues every expected change of the output vector; a monitor checks them.
module tb_m_game_ctrl;
    import m_game_ctrl_pkg::*;

    localparam logic [7:0] WIN = 8'd188;
    localparam int         TMO = 1023;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       hs_enable = 1'b0;
    logic       start_key = 1'b0;
    logic       logic_finished = 1'b0;
    logic       collision_finished = 1'b0;
    logic       ghost_collision = 1'b0;
    logic       render_finished = 1'b0;
    logic [7:0] score = 8'd0;
    logic       logic_enable, collision_enable, render_enable, stage_ack, game_reset;
    logic       game_won, game_over, fault;
    logic [3:0] overrun_count, state_dbg;

    m_game_ctrl #(.WON_SCORE(WIN), .TIMEOUT(TMO)) dut (
        .clock              (clock),
        .reset              (reset),
        .hs_enable          (hs_enable),
        .start_key          (start_key),
        .logic_finished     (logic_finished),
        .collision_finished (collision_finished),
        .ghost_collision    (ghost_collision),
        .render_finished    (render_finished),
        .score              (score),
        .logic_enable       (logic_enable),
        .collision_enable   (collision_enable),
        .render_enable      (render_enable),
        .stage_ack          (stage_ack),
        .game_reset         (game_reset),
        .game_won           (game_won),
        .game_over          (game_over),
        .fault              (fault),
        .overrun_count      (overrun_count),
        .state_dbg          (state_dbg)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [15:0] snap;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    // Game-level reference: where the game is, which stage runs, how long it has run.
    typedef enum {M_IDLE, M_WAIT, M_RUN, M_CHECK, M_WON, M_LOST, M_FAULT} mode_t;
    mode_t       m_mode = M_IDLE;
    int          m_stage = 0;
    int          m_held = 0;
    bit          m_pend = 1'b0;
    int          m_ovr = 0;
    bit          m_hit = 1'b0;
    logic [15:0] m_last = 'x;

    int fin_delay = 3;
    int noise = 0;
    bit gc_val = 1'b0;

    function automatic logic [3:0] dbg_of(mode_t mo, int st);
        case (mo)
            M_IDLE:  return S_IDLE;
            M_WAIT:  return S_WAIT_TICK;
            M_RUN:   return (st == 0) ? S_LOGIC : (st == 1) ? S_COLLIDE : S_RENDER;
            M_CHECK: return S_CHECK;
            M_WON:   return S_WON;
            M_LOST:  return S_LOST;
            default: return S_FAULT;
        endcase
    endfunction

    task automatic model_cycle();
        logic [15:0] e;
        logic [2:0]  en;
        logic        fin, gr;
        bit          pend_old;
        if (reset) begin
            e = {8'h00, 4'd0, dbg_of(M_IDLE, 0)};
            m_mode = M_IDLE; m_stage = 0; m_held = 0;
            m_pend = 1'b0; m_ovr = 0; m_hit = 1'b0;
        end else begin
            fin = 1'b0;
            en  = 3'b000;
            if (m_mode == M_RUN) begin
                fin = (m_stage == 0) ? logic_finished :
                      (m_stage == 1) ? collision_finished : render_finished;
                en = 3'b100 >> m_stage;
            end
            gr = start_key && (m_mode inside {M_IDLE, M_WON, M_LOST});
            e = {en, fin, gr, m_mode == M_WON, m_mode == M_LOST, m_mode == M_FAULT,
                 4'(m_ovr), dbg_of(m_mode, m_stage)};
            pend_old = m_pend;
            if ((m_mode inside {M_WAIT, M_RUN, M_CHECK}) && hs_enable) begin
                if (m_pend && m_ovr < 15) m_ovr++;
                m_pend = 1'b1;
            end
            case (m_mode)
                M_IDLE, M_WON, M_LOST: if (start_key) begin
                    m_mode = M_WAIT; m_ovr = 0; m_pend = 1'b0; m_hit = 1'b0;
                end
                M_WAIT: if (pend_old || hs_enable) begin
                    m_mode = M_RUN; m_stage = 0; m_held = 0; m_pend = 1'b0;
                end
                M_RUN: begin
                    m_held++;
                    if (fin) begin
                        if (m_stage == 1) m_hit = ghost_collision;
                        m_held = 0;
                        if (m_stage == 2) m_mode = M_CHECK;
                        else m_stage++;
                    end else if (m_held >= TMO) begin
                        m_mode = M_FAULT;
                    end
                end
                M_CHECK: m_mode = m_hit ? M_LOST : ((score >= WIN) ? M_WON : M_WAIT);
                default: ;
            endcase
        end
        if (e !== m_last) begin
            sb.push_back('{cyc, e});
            m_last = e;
        end
    endtask

    function automatic logic agent_fin(int s);
        logic n;
        n = (noise > 0) && (int'($urandom_range(0, 99)) < noise);
        return ((m_mode == M_RUN) && (m_stage == s) && (m_held >= fin_delay)) || n;
    endfunction

    task automatic step(input logic hs, input logic sk);
        hs_enable          = hs;
        start_key          = sk;
        logic_finished     = agent_fin(0);
        collision_finished = agent_fin(1);
        render_finished    = agent_fin(2);
        ghost_collision    = gc_val;
        model_cycle();
        @(posedge clock);
        #1;
        cyc++;
        hs_enable = 1'b0;
        start_key = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    task automatic wait_mode(input mode_t target, input int budget);
        int n = 0;
        while (m_mode != target && n < budget) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (m_mode != target) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_mode budget expired cyc=%0d got mode %0d required %0d", cyc, m_mode, target);
        end
    endtask

    task automatic wait_stage(input int s, input int budget);
        int n = 0;
        while (!(m_mode == M_RUN && m_stage == s) && n < budget) begin
            step(1'b0, 1'b0);
            n++;
        end
        if (!(m_mode == M_RUN && m_stage == s)) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_stage budget expired cyc=%0d got stage %0d required %0d", cyc, m_stage, s);
        end
    endtask

    // Monitor: every change of the DUT output vector must match the next queued expectation.
    initial begin
        logic [15:0] last;
        logic [15:0] snap;
        exp_t        x;
        last = 'x;
        forever begin
            @(negedge clock);
            snap = {logic_enable, collision_enable, render_enable, stage_ack, game_reset,
                    game_won, game_over, fault, overrun_count, state_dbg};
            if (snap !== last) begin
                last = snap;
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_change cyc=%0d got=%h required=<no change>", cyc, snap);
                end else begin
                    x = sb.pop_front();
                    if (x.snap !== snap || x.cyc != cyc) begin
                        miscompares++;
                        $display("FAIL output_vector got=%h at cyc %0d required=%h at cyc %0d",
                                 snap, cyc, x.snap, x.cyc);
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clock);
        #1;
        reset = 1'b1; run(3); reset = 1'b0; run(2);

        // Normal frame, stages finish 3 cycles after enable.
        fin_delay = 3; gc_val = 1'b0; score = 8'd10;
        step(1'b0, 1'b1); run(2); step(1'b1, 1'b0);
        wait_mode(M_WAIT, 40); run(3);

        // Collision beats a winning score.
        gc_val = 1'b1; score = 8'd188;
        step(1'b1, 1'b0); wait_mode(M_LOST, 40); run(3);
        step(1'b0, 1'b1); run(2);

        // Exact winning score, then restart from WON.
        gc_val = 1'b0; score = 8'd188;
        step(1'b1, 1'b0); wait_mode(M_WON, 40); run(2);
        step(1'b0, 1'b1); run(2);
        score = 8'd187;
        step(1'b1, 1'b0); wait_mode(M_WAIT, 40); run(2);

        // Ticks piling up while LOGIC stalls: one to arm, seventeen more to saturate.
        score = 8'd0; fin_delay = 200;
        step(1'b1, 1'b0);
        repeat (18) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
        fin_delay = 2;
        wait_mode(M_CHECK, 20); wait_mode(M_WAIT, 20); run(2);
        reset = 1'b1; run(2); reset = 1'b0; run(1);

        // Reset while COLLIDE is enabled and reporting finished.
        fin_delay = 4;
        step(1'b0, 1'b1); step(1'b1, 1'b0);
        wait_stage(1, 30); run(2);
        fin_delay = 2;
        reset = 1'b1; step(1'b0, 1'b0); step(1'b0, 1'b0); reset = 1'b0; run(3);

        // Randomised play with stray finished flags and occasional resets.
        noise = 5;
        for (int i = 0; i < 1500; i++) begin
            if (i % 40 == 0) fin_delay = $urandom_range(0, 6);
            gc_val = ($urandom_range(0, 3) == 0);
            score  = 8'($urandom_range(170, 200));
            reset  = ($urandom_range(0, 299) == 0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
        end
        noise = 0;
        reset = 1'b1; run(2); reset = 1'b0; run(2);

        // RENDER never finishes: watchdog fault, inputs ignored, only reset exits.
        gc_val = 1'b0; score = 8'd0; fin_delay = 2;
        step(1'b0, 1'b1); step(1'b1, 1'b0);
        wait_stage(2, 50);
        fin_delay = 100000;
        wait_mode(M_FAULT, 1100); run(5);
        noise = 50;
        repeat (20) step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        noise = 0;
        run(2);
        reset = 1'b1; run(2); reset = 1'b0; run(3);

        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL missing_changes got %0d expectations left required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
